pipe_bcla_adder: RTL and testbench
==================================

PIPE_BCLA_ADDER -- requirements
Module: pipe_bcla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 SHALL have parameter BLOCK, default 4: bits per carry look-ahead block.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream offers an operation.
REQ-006 SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-007 SHALL have port x  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 SHALL have port y  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in; for subtraction, 1 means no borrow.
REQ-010 SHALL have port sub  input  1  1 selects subtract mode (B inverted).
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  downstream consumes the result this cycle.
REQ-013 SHALL have port s  output  WIDTH  sum.
REQ-014 SHALL have port cout  output  1  carry-out of the MSB.

Function
REQ-015 SHALL compute {cout,s} = x + (sub ? ~y : y) + cin, exact over WIDTH+1 bits.
REQ-016 SHALL accept an operation when in_valid && in_ready at a rising edge, and transfer a result when out_valid && out_ready.
REQ-017 SHALL be a 2-stage pipeline: stage 1 registers per-bit P/G and per-block group G/P; stage 2 resolves inter-block carries by look-ahead and registers s/cout.
REQ-018 SHALL present out_valid 2 edges after acceptance when not stalled; throughput one operation per cycle.
REQ-019 SHALL drive in_ready = !v1 || !v2 || out_ready (v1/v2 = stage valid flags); stage 1 advances only when stage 2 is empty or draining.
REQ-020 SHALL hold s, cout (and ovf) stable while out_valid && !out_ready.
REQ-021 SHALL preserve order; no operation lost or duplicated under any in_valid/out_ready pattern.
REQ-022 SHALL accept and emit in the same cycle when the pipe is full and out_ready=1.
REQ-023 SHALL not combinationally depend on in_valid for in_ready.
REQ-024 SHALL reject at elaboration WIDTH % BLOCK != 0, BLOCK < 2, or WIDTH < BLOCK.

Reset
REQ-025 SHALL, on rst_n low, immediately clear v1, v2, out_valid, s, cout, ovf to 0.
REQ-026 SHALL discard all in-flight operations on reset mid-operation; no stale result after release.
REQ-027 SHALL assert in_ready in the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL, with PIPE_BCLA_ADDER_OVF_EN defined, add port ovf  output  1  signed overflow = carry into MSB XOR cout, pipelined and stalled with s.
REQ-029 SHALL, without PIPE_BCLA_ADDER_OVF_EN, have no ovf port and no overflow logic; all other behaviour identical.

Structure
REQ-030 SHALL place default WIDTH/BLOCK constants and a stage-1 record typedef (P, G, group G/P, cin) in package pipe_bcla_pkg.
REQ-031 SHALL use one sub-module, bcla_group, computing one block's group G/P from BLOCK-bit P/G, instantiated WIDTH/BLOCK times.

Verification (WIDTH=8, BLOCK=4 unless stated)
REQ-032 SHALL check x=0xFF, y=0x01, cin=0, sub=0 -> s=0x00, cout=1, out_valid exactly 2 edges after accept.
REQ-033 SHALL check x=0x05, y=0x07, cin=1, sub=1 -> s=0xFE, cout=0 (borrow); with OVF_EN ovf=0.
REQ-034 SHALL check x=0x7F, y=0x01, cin=0, sub=0 with OVF_EN -> s=0x80, cout=0, ovf=1.
REQ-035 SHALL check 3 back-to-back ops with out_ready=0 for 4 cycles -> in_ready=0 once both stages full, results emitted in order, none lost.
REQ-036 SHALL check rst_n pulsed low with both stages valid -> out_valid=0 asynchronously, s=0, no output after release until a new accept.
REQ-037 SHALL run 10k random ops with random handshake stalls, WIDTH=32, BLOCK in {4,8}, against a behavioural x+y model, macro on and off.

Source files
------------

// File: rtl/pipe_bcla_pkg.sv
// Shared constants and stage-1 record element types for the pipelined
// block carry look-ahead adder.
package pipe_bcla_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned DEFAULT_BLOCK = 4;

   // Per-bit propagate/generate pair.
   typedef struct packed {
      logic p;
      logic g;
   } bit_pg_t;

   // Per-block group generate/propagate pair.
   typedef struct packed {
      logic gg;
      logic gp;
   } grp_pg_t;

endpackage

// File: rtl/pipe_bcla_adder_bcla_group.sv
// One carry look-ahead block: reduces BLOCK bits of P/G into the group
// generate and group propagate terms.
module bcla_group
   import pipe_bcla_pkg::*;
#(
   parameter int unsigned BLOCK = DEFAULT_BLOCK
) (
   input  logic [BLOCK-1:0] p,
   input  logic [BLOCK-1:0] g,
   output logic             gg,
   output logic             gp
);

   always_comb begin
      gg = g[0];
      gp = p[0];
      for (int unsigned i = 1; i < BLOCK; i++) begin
         gg = g[i] | (p[i] & gg);
         gp = gp & p[i];
      end
   end

endmodule

// File: rtl/pipe_bcla_adder.sv
// Two-stage pipelined block carry look-ahead adder with valid/ready flow
// control. Define PIPE_BCLA_ADDER_OVF_EN to add the signed-overflow output.
module pipe_bcla_adder
   import pipe_bcla_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned BLOCK = DEFAULT_BLOCK
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef PIPE_BCLA_ADDER_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int unsigned NGRP = WIDTH / BLOCK;

   if ((WIDTH % BLOCK) != 0 || BLOCK < 2 || WIDTH < BLOCK) begin : g_bad_cfg
      $error("pipe_bcla_adder: WIDTH must be a multiple of BLOCK, BLOCK >= 2, WIDTH >= BLOCK");
   end

   typedef struct packed {
      bit_pg_t [WIDTH-1:0] bits;
      grp_pg_t [NGRP-1:0]  grps;
      logic                cin;
   } stage1_t;

   logic [WIDTH-1:0] y_eff;
   logic [WIDTH-1:0] p_in;
   logic [WIDTH-1:0] g_in;
   logic [NGRP-1:0]  gg_in;
   logic [NGRP-1:0]  gp_in;
   stage1_t          s1_new;

   logic             adv1;
   logic             adv2;
   logic             v1_d, v1_q;
   logic             v2_d, v2_q;
   stage1_t          s1_d, s1_q;
   logic [WIDTH-1:0] s_d, s_q;
   logic             cout_d, cout_q;

   logic [NGRP:0]    blk_c;
   logic [WIDTH-1:0] sum_n;
   logic             carry;
   logic             term;
   logic             bit_c;
   logic             msb_cin;
`ifdef PIPE_BCLA_ADDER_OVF_EN
   logic             ovf_d, ovf_q;
`endif

   // ---------------- stage 1: per-bit and per-block P/G ----------------
   always_comb begin
      y_eff = sub ? ~y : y;
      p_in  = x ^ y_eff;
      g_in  = x & y_eff;
   end

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      bcla_group #(.BLOCK(BLOCK)) u_grp (
         .p  (p_in[k*BLOCK +: BLOCK]),
         .g  (g_in[k*BLOCK +: BLOCK]),
         .gg (gg_in[k]),
         .gp (gp_in[k])
      );
   end

   always_comb begin
      s1_new = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         s1_new.bits[i].p = p_in[i];
         s1_new.bits[i].g = g_in[i];
      end
      for (int unsigned k = 0; k < NGRP; k++) begin
         s1_new.grps[k].gg = gg_in[k];
         s1_new.grps[k].gp = gp_in[k];
      end
      s1_new.cin = cin;
   end

   // ---------------- stage 2: block carries and sum ----------------
   // Each block carry is a flat sum of products over the group terms below it,
   // so no carry ripples from block to block.
   always_comb begin
      blk_c    = '0;
      carry    = 1'b0;
      term     = 1'b0;
      blk_c[0] = s1_q.cin;
      for (int unsigned k = 1; k <= NGRP; k++) begin
         carry = s1_q.cin;
         for (int unsigned j = 0; j < k; j++) begin
            carry = carry & s1_q.grps[j].gp;
         end
         for (int unsigned j = 0; j < k; j++) begin
            term = s1_q.grps[j].gg;
            for (int unsigned m = j + 1; m < k; m++) begin
               term = term & s1_q.grps[m].gp;
            end
            carry = carry | term;
         end
         blk_c[k] = carry;
      end
   end

   always_comb begin
      sum_n   = '0;
      bit_c   = 1'b0;
      msb_cin = 1'b0;
      for (int unsigned k = 0; k < NGRP; k++) begin
         bit_c = blk_c[k];
         for (int unsigned b = 0; b < BLOCK; b++) begin
            if (k * BLOCK + b == WIDTH - 1) begin
               msb_cin = bit_c;
            end
            sum_n[k*BLOCK + b] = s1_q.bits[k*BLOCK + b].p ^ bit_c;
            bit_c = s1_q.bits[k*BLOCK + b].g | (s1_q.bits[k*BLOCK + b].p & bit_c);
         end
      end
   end

   // ---------------- handshake and next state ----------------
   always_comb begin
      adv2   = !v2_q || out_ready;
      adv1   = !v1_q || adv2;
      v1_d   = adv1 ? in_valid : v1_q;
      s1_d   = (adv1 && in_valid) ? s1_new : s1_q;
      v2_d   = adv2 ? v1_q : v2_q;
      s_d    = (adv2 && v1_q) ? sum_n : s_q;
      cout_d = (adv2 && v1_q) ? blk_c[NGRP] : cout_q;
   end

`ifdef PIPE_BCLA_ADDER_OVF_EN
   always_comb begin
      ovf_d = (adv2 && v1_q) ? (msb_cin ^ blk_c[NGRP]) : ovf_q;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         s1_q   <= '0;
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         s1_q   <= s1_d;
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

`ifdef PIPE_BCLA_ADDER_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   always_comb begin
      ovf = ovf_q;
   end
`else
   logic unused_msb_cin;
   always_comb begin
      unused_msb_cin = msb_cin;
   end
`endif

   always_comb begin
      in_ready  = adv1;
      out_valid = v2_q;
      s         = s_q;
      cout      = cout_q;
   end

endmodule

// File: tb/tb_pipe_bcla_adder.sv
// Directed and stalled-stream checks for pipe_bcla_adder (WIDTH=8, BLOCK=4).
module tb_pipe_bcla_adder;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] s;
   logic         cout;
`ifdef PIPE_BCLA_ADDER_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic         ovf;
      logic         cout;
      logic [W-1:0] s;
   } res_t;

   res_t        exp_q[$];
   res_t        mon_r;
   int unsigned n_acc = 0;

   pipe_bcla_adder #(.WIDTH(W), .BLOCK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout)
`ifdef PIPE_BCLA_ADDER_OVF_EN
     ,.ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input logic sb);
      res_t         r;
      logic [W-1:0] bb;
      logic [W:0]   full;
      bb     = sb ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
      r.s    = full[W-1:0];
      r.cout = full[W];
      r.ovf  = (a[W-1] == bb[W-1]) && (r.s[W-1] != a[W-1]);
      return r;
   endfunction

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic sb);
      x   = a;
      y   = b;
      cin = c;
      sub = sb;
   endtask

   // Scoreboard: transfers decided by the values held before each rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
               mon_r = exp_q.pop_front();
               check_eq("sb_s", 32'(s), 32'(mon_r.s));
               check_eq("sb_cout", 32'(cout), 32'(mon_r.cout));
`ifdef PIPE_BCLA_ADDER_OVF_EN
               check_eq("sb_ovf", 32'(ovf), 32'(mon_r.ovf));
`endif
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(x, y, cin, sub));
            n_acc++;
         end
      end
   end

   initial begin
      int unsigned target;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      drive_op(8'h00, 8'h00, 1'b0, 1'b0);

      #3;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_s", 32'(s), 32'd0);
      check_eq("rst_cout", 32'(cout), 32'd0);
      #14 rst_n = 1'b1;
      #1;
      check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
      step_clk();

      // 0xFF + 0x01: wraps to zero with carry-out, two edges of latency
      out_ready = 1'b1;
      drive_op(8'hFF, 8'h01, 1'b0, 1'b0);
      in_valid = 1'b1;
      step_clk();
      in_valid = 1'b0;
      check_eq("lat_edge1_out_valid", 32'(out_valid), 32'd0);
      step_clk();
      check_eq("lat_edge2_out_valid", 32'(out_valid), 32'd1);
      check_eq("ff_plus_1_s", 32'(s), 32'h00);
      check_eq("ff_plus_1_cout", 32'(cout), 32'd1);
      step_clk();
      check_eq("ff_plus_1_drained", 32'(out_valid), 32'd0);

      // 5 - 7 with cin=1: borrow, result -2
      drive_op(8'h05, 8'h07, 1'b1, 1'b1);
      in_valid = 1'b1;
      step_clk();
      in_valid = 1'b0;
      step_clk();
      check_eq("sub_out_valid", 32'(out_valid), 32'd1);
      check_eq("sub_s", 32'(s), 32'hFE);
      check_eq("sub_cout", 32'(cout), 32'd0);
`ifdef PIPE_BCLA_ADDER_OVF_EN
      check_eq("sub_ovf", 32'(ovf), 32'd0);
`endif
      step_clk();

      // 0x7F + 0x01: signed overflow
      drive_op(8'h7F, 8'h01, 1'b0, 1'b0);
      in_valid = 1'b1;
      step_clk();
      in_valid = 1'b0;
      step_clk();
      check_eq("ovf_s", 32'(s), 32'h80);
      check_eq("ovf_cout", 32'(cout), 32'd0);
`ifdef PIPE_BCLA_ADDER_OVF_EN
      check_eq("ovf_ovf", 32'(ovf), 32'd1);
`endif
      step_clk();

      // 0 - 0 with cin=1: all-ones inverted operand, full carry chain
      drive_op(8'h00, 8'h00, 1'b1, 1'b1);
      in_valid = 1'b1;
      step_clk();
      in_valid = 1'b0;
      step_clk();
      check_eq("zero_sub_s", 32'(s), 32'h00);
      check_eq("zero_sub_cout", 32'(cout), 32'd1);
      step_clk();

      // Three back-to-back ops against a stalled consumer
      out_ready = 1'b0;
      drive_op(8'h10, 8'h20, 1'b0, 1'b0);
      in_valid = 1'b1;
      step_clk();
      drive_op(8'h80, 8'h80, 1'b0, 1'b0);
      step_clk();
      drive_op(8'h03, 8'h01, 1'b1, 1'b1);
      check_eq("full_in_ready", 32'(in_ready), 32'd0);
      check_eq("full_out_valid", 32'(out_valid), 32'd1);
      check_eq("full_s", 32'(s), 32'h30);
      for (int i = 0; i < 3; i++) begin
         step_clk();
         check_eq("stall_in_ready", 32'(in_ready), 32'd0);
         check_eq("stall_s_hold", 32'(s), 32'h30);
         check_eq("stall_cout_hold", 32'(cout), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check_eq("full_drain_in_ready", 32'(in_ready), 32'd1);
      step_clk();
      in_valid = 1'b0;
      check_eq("order_b_s", 32'(s), 32'h00);
      check_eq("order_b_cout", 32'(cout), 32'd1);
      step_clk();
      check_eq("order_c_s", 32'(s), 32'h02);
      check_eq("order_c_cout", 32'(cout), 32'd1);
      step_clk();
      check_eq("order_empty", 32'(out_valid), 32'd0);
      check_eq("order_none_lost", 32'(exp_q.size()), 32'd0);

      // Reset with both stages occupied
      out_ready = 1'b0;
      drive_op(8'h11, 8'h22, 1'b0, 1'b0);
      in_valid = 1'b1;
      step_clk();
      drive_op(8'h33, 8'h44, 1'b0, 1'b0);
      step_clk();
      in_valid = 1'b0;
      check_eq("pre_rst_out_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("async_rst_s", 32'(s), 32'd0);
      check_eq("async_rst_cout", 32'(cout), 32'd0);
      exp_q.delete();
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step_clk();
         check_eq("no_stale_out", 32'(out_valid), 32'd0);
      end

      // Random operands with random handshake stalls
      target = n_acc + 300;
      for (int cyc = 0; cyc < 4000 && n_acc < target; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         drive_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         step_clk();
      end
      check_eq("rand_accepts", 32'(n_acc >= target), 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && exp_q.size() != 0; cyc++) begin
         step_clk();
      end
      step_clk();
      check_eq("rand_drain_empty", 32'(exp_q.size()), 32'd0);
      check_eq("rand_final_out_valid", 32'(out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
